// File: rtl/wb_arbiter_pkg.sv
// Shared constants and the write-port bundle for the writeback arbiter.
// Define WB_ARB_RR_EN for round-robin priority; default is fixed priority.
package wb_arbiter_pkg;

    localparam int WB_XLEN  = 32;
    localparam int REG_W    = 5;
    localparam int GID_W    = 2;
    localparam int NREQ_DEF = 3;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_CSR  = 2;

    typedef struct packed {
        logic               en;
        logic [REG_W-1:0]   num;
        logic [WB_XLEN-1:0] data;
    } wb_port_t;

endpackage

// File: rtl/wb_rr_pick.sv
// One-hot grant picker; rotating priority from ptr_i when WB_ARB_RR_EN
// is defined, otherwise fixed priority with the lowest index first.
module wb_rr_pick
    import wb_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [GID_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o
);

`ifdef WB_ARB_RR_EN
    int idx;

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        grant_o = '0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (valid_i[idx]) begin
                grant_o = NREQ'(1) << idx;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        grant_o = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid_i[k]) begin
                grant_o = NREQ'(1) << k;
            end
        end
    end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one requester per cycle to the register-file
// write port with a registered output stage. Priority mode set by WB_ARB_RR_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int XLEN = WB_XLEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        ReqValid,
    input  logic [REG_W*NREQ-1:0]  ReqNum,
    input  logic [XLEN*NREQ-1:0]   ReqData,
    output logic [NREQ-1:0]        ReqReady,
    input  logic                   WbStall,
    output logic                   WriteBackReg,
    output logic [REG_W-1:0]       WriteBackNum,
    output logic [XLEN-1:0]        WriteBackData,
    output logic [GID_W-1:0]       GrantId
);

    logic [NREQ-1:0]  pick_gnt;
    logic [NREQ-1:0]  gnt;
    logic [GID_W-1:0] ptr_q;
    logic [GID_W-1:0] sel_id;
    logic [REG_W-1:0] sel_num;
    logic [XLEN-1:0]  sel_data;

    logic             en_d,   en_q;
    logic [REG_W-1:0] num_d,  num_q;
    logic [XLEN-1:0]  data_d, data_q;
    logic [GID_W-1:0] gid_d,  gid_q;

    wb_rr_pick #(.NREQ(NREQ)) u_pick (
        .valid_i (ReqValid & {NREQ{~WbStall}}),
        .ptr_i   (ptr_q),
        .grant_o (pick_gnt)
    );

    // Reset gates the grant so nothing is consumed while rst_n is low.
    assign gnt      = pick_gnt & {NREQ{rst_n}};
    assign ReqReady = gnt;

    always_comb begin
        sel_id   = '0;
        sel_num  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_id   = GID_W'(i);
                sel_num  = ReqNum[REG_W*i +: REG_W];
                sel_data = ReqData[XLEN*i +: XLEN];
            end
        end
    end

    always_comb begin
        en_d   = 1'b0;
        num_d  = num_q;
        data_d = data_q;
        gid_d  = gid_q;
        if (|gnt) begin
            en_d   = (sel_num != '0);
            num_d  = sel_num;
            data_d = sel_data;
            gid_d  = sel_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            num_q  <= '0;
            data_q <= '0;
            gid_q  <= '0;
        end else begin
            en_q   <= en_d;
            num_q  <= num_d;
            data_q <= data_d;
            gid_q  <= gid_d;
        end
    end

`ifdef WB_ARB_RR_EN
    logic [GID_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (|gnt) begin
            ptr_d = (int'(sel_id) == NREQ - 1) ? '0 : sel_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign ptr_q = '0;
`endif

    assign WriteBackReg  = en_q;
    assign WriteBackNum  = num_q;
    assign WriteBackData = data_q;
    assign GrantId       = gid_q;

endmodule
